// File: rtl/nl_engine.sv
// Streaming elementwise activation engine: one tensor of 16-bit words per start,
// single registered output stage, dimensions and emitted-length status for the NL register file.
module nl_engine #(
    parameter int DW    = 16,
    parameter int CNT_W = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   data_wid,
    input  logic [15:0]   data_hei,
    input  logic [15:0]   data_ch,
    input  logic [15:0]   nl_type,
    input  logic [15:0]   input_data_format,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [15:0]   output_wid,
    output logic [15:0]   output_hei,
    output logic [15:0]   output_ch,
    output logic [15:0]   output_data_length
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [DW-1:0] RELU6_MAX = DW'(16'h0600);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [15:0]        type_q, type_d;
    logic               sgn_q, sgn_d;
    logic [15:0]        wid_q, wid_d, hei_q, hei_d, ch_q, ch_d;
    logic [15:0]        len_q, len_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [DW-1:0]      out_data_q, out_data_d;

    logic [31:0]        wh_prod;
    logic [CNT_W-1:0]   total_prod;
    logic               in_fire, out_fire;
    logic               unused_fmt_bits;

    // Only bit0 of the format register carries meaning.
    assign unused_fmt_bits = ^input_data_format[15:1];

    assign wh_prod    = {16'b0, data_wid} * {16'b0, data_hei};
    assign total_prod = {{(CNT_W-32){1'b0}}, wh_prod} * {{(CNT_W-16){1'b0}}, data_ch};

    function automatic logic [DW-1:0] apply_nl(input logic [15:0] t, input logic sgn,
                                               input logic [DW-1:0] x);
        logic                 neg;
        logic signed [DW-1:0] xs;
        logic signed [DW-1:0] shr;
        logic [DW-1:0]        r;
        neg = sgn & x[DW-1];
        xs  = x;
        shr = xs >>> 3;
        r   = x;
        case (t)
            16'd1: r = neg ? '0 : x;
            16'd2: r = neg ? shr : x;
            // Non-negative values compare as unsigned in both formats.
            16'd3: r = neg ? '0 : ((x > RELU6_MAX) ? RELU6_MAX : x);
            default: r = x;
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == S_RUN) && (in_cnt_q < total_q) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        in_cnt_d    = in_cnt_q;
        type_d      = type_q;
        sgn_d       = sgn_q;
        wid_d       = wid_q;
        hei_d       = hei_q;
        ch_d        = ch_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d     = total_prod;
                    in_cnt_d    = '0;
                    len_d       = '0;
                    type_d      = nl_type;
                    sgn_d       = input_data_format[0];
                    wid_d       = data_wid;
                    hei_d       = data_hei;
                    ch_d        = data_ch;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = (total_prod == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = apply_nl(type_q, sgn_q, in_data);
                    out_last_d  = (in_cnt_q == total_q - CNT_W'(1));
                    in_cnt_d    = in_cnt_q + CNT_W'(1);
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (out_fire) begin
                    if (len_q != 16'hFFFF) begin
                        len_d = len_q + 16'd1;
                    end
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            in_cnt_q    <= '0;
            type_q      <= '0;
            sgn_q       <= 1'b0;
            wid_q       <= '0;
            hei_q       <= '0;
            ch_q        <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            in_cnt_q    <= in_cnt_d;
            type_q      <= type_d;
            sgn_q       <= sgn_d;
            wid_q       <= wid_d;
            hei_q       <= hei_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_last           = out_last_q;
    assign busy               = (state_q == S_RUN);
    assign done               = (state_q == S_DONE);
    assign output_wid         = wid_q;
    assign output_hei         = hei_q;
    assign output_ch          = ch_q;
    assign output_data_length = len_q;

endmodule

// File: tb/tb_nl_engine.sv
// Scoreboard bench for nl_engine: directed cases plus randomized tensors checked against
// an arithmetic reference model of the activation rules.
module tb_nl_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_wid = '0, data_hei = '0, data_ch = '0;
    logic [15:0] nl_type = '0, input_data_format = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy, done;
    logic [15:0] output_wid, output_hei, output_ch, output_data_length;

    nl_engine #(.DW(16), .CNT_W(48)) dut (
        .clk(clk), .rst(rst), .start(start),
        .data_wid(data_wid), .data_hei(data_hei), .data_ch(data_ch),
        .nl_type(nl_type), .input_data_format(input_data_format),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done),
        .output_wid(output_wid), .output_hei(output_hei), .output_ch(output_ch),
        .output_data_length(output_data_length)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];
    logic [15:0] cur_type = '0;
    bit          cur_sgn = 1'b0;
    longint      cur_total = 0;
    longint      exp_idx = 0;
    bit          bp = 1'b0;
    bit          expect_done = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] st_data = '0;
    logic        st_last = 1'b0;
    logic [15:0] stim [0:63];
    logic [15:0] corner [0:7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: interpret the word as an integer, apply the rule, keep low 16 bits.
    function automatic logic [15:0] model(input logic [15:0] t, input bit sgn, input logic [15:0] x);
        int v;
        v = sgn ? int'($signed(x)) : int'(x);
        case (t)
            16'd1: if (v < 0) v = 0;
            16'd2: if (v < 0) v = (v - 7) / 8;
            16'd3: begin
                if (v < 0) v = 0;
                else if (v > 1536) v = 1536;
            end
            default: ;
        endcase
        return v[15:0];
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = bp ? ~out_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back({(exp_idx == cur_total - 1), model(cur_type, cur_sgn, in_data)});
            exp_idx++;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            stalled     = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                chk("done_after_last", done, 1);
                expect_done = 1'b0;
            end
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, st_data);
                chk("stall_last", out_last, st_last);
            end
            if (out_valid && !out_ready) chk("in_ready_blocked", in_ready, 0);
            stalled = out_valid && !out_ready;
            st_data = out_data;
            st_last = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out data=%04h last=%0b exp=%04h/%0b", out_data, out_last, e[15:0], e[16]);
                    chk("out_data", out_data, e[15:0]);
                    chk("out_last", out_last, e[16]);
                    if (out_last) expect_done = 1'b1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dims", {output_wid, output_hei, output_ch}, 0);
        chk("rst_len", output_data_length, 0);
    endtask

    task automatic start_tensor(input logic [15:0] w, input logic [15:0] h, input logic [15:0] c,
                                input logic [15:0] t, input logic [15:0] f);
        data_wid = w; data_hei = h; data_ch = c; nl_type = t; input_data_format = f;
        cur_type  = t;
        cur_sgn   = f[0];
        cur_total = longint'(w) * longint'(h) * longint'(c);
        exp_idx   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (cur_total != 0) begin
            chk("busy_after_start", busy, 1);
            chk("in_ready_after_start", in_ready, 1);
        end
    endtask

    task automatic feed(input int n, input bit mid_start, input bit gaps);
        bit hs;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            if (mid_start && i == 2) begin
                start = 1'b1; data_wid = 16'd7; data_ch = 16'd3; nl_type = 16'd0;
            end
            hs = 1'b0;
            for (int k = 0; k < 200 && !hs; k++) begin
                @(negedge clk);
                hs = in_ready;
                tick();
                start = 1'b0;
            end
            if (!hs) begin
                chk("feed_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_tensor(input int n, input logic [15:0] w, input logic [15:0] h,
                                 input logic [15:0] c);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", seen, 1);
        chk("out_len", output_data_length, n);
        chk("out_wid", output_wid, w);
        chk("out_hei", output_hei, h);
        chk("out_ch", output_ch, c);
        chk("queue_empty", exp_q.size(), 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
        $display("tensor %0dx%0dx%0d done, len=%0d", w, h, c, output_data_length);
    endtask

    initial begin
        int w, h, c, n;
        corner[0] = 16'h0600; corner[1] = 16'h0601; corner[2] = 16'h05FF; corner[3] = 16'h8000;
        corner[4] = 16'hFFFF; corner[5] = 16'h7FFF; corner[6] = 16'h0000; corner[7] = 16'hFFF8;

        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        // ReLU signed 2x2x1
        stim[0] = 16'h0010; stim[1] = 16'hFFF0; stim[2] = 16'h7FFF; stim[3] = 16'h8000;
        start_tensor(2, 2, 1, 1, 1);
        feed(4, 0, 0);
        finish_tensor(4, 2, 2, 1);

        // Leaky ReLU signed
        stim[0] = 16'hFF00; stim[1] = 16'h0010; stim[2] = 16'h8000; stim[3] = 16'hFFFF;
        start_tensor(1, 1, 4, 2, 1);
        feed(4, 0, 0);
        finish_tensor(4, 1, 1, 4);

        // ReLU6 signed and unsigned
        stim[0] = 16'h0700; stim[1] = 16'hFF00; stim[2] = 16'h0600; stim[3] = 16'h0601;
        start_tensor(1, 1, 4, 3, 1);
        feed(4, 0, 0);
        finish_tensor(4, 1, 1, 4);
        stim[0] = 16'hFF00; stim[1] = 16'h0500; stim[2] = 16'h0601; stim[3] = 16'h8000;
        start_tensor(1, 1, 4, 3, 16'hFFFE);
        feed(4, 0, 0);
        finish_tensor(4, 1, 1, 4);

        // Backpressure passthrough
        for (int i = 0; i < 8; i++) stim[i] = 16'(i * 16'h1111 + 16'h0102);
        bp = 1'b1;
        start_tensor(1, 1, 8, 0, 0);
        feed(8, 0, 0);
        finish_tensor(8, 1, 1, 8);
        bp = 1'b0;

        // Zero dimension
        start_tensor(3, 2, 0, 1, 1);
        chk("zero_done", done, 1);
        chk("zero_in_ready", in_ready, 0);
        chk("zero_busy", busy, 0);
        chk("zero_len", output_data_length, 0);
        chk("zero_wid", output_wid, 3);
        tick();
        chk("zero_done_clear", done, 0);
        chk("zero_in_ready2", in_ready, 0);

        // Start while busy is ignored
        for (int i = 0; i < 8; i++) stim[i] = 16'($urandom);
        start_tensor(2, 2, 2, 1, 1);
        feed(8, 1, 1);
        finish_tensor(8, 2, 2, 2);

        // Reset after 3 of 8
        for (int i = 0; i < 8; i++) stim[i] = 16'($urandom);
        start_tensor(1, 1, 8, 2, 1);
        feed(3, 0, 0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_vals();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_done_after_rst", done, 0);
        end
        start_tensor(1, 1, 8, 2, 1);
        feed(8, 0, 0);
        finish_tensor(8, 1, 1, 8);

        // Randomized tensors
        for (int r = 0; r < 10; r++) begin
            w = $urandom_range(1, 3); h = $urandom_range(1, 3); c = $urandom_range(1, 3);
            n = w * h * c;
            for (int i = 0; i < n; i++)
                stim[i] = ($urandom_range(2) == 0) ? corner[$urandom_range(7)] : 16'($urandom);
            bp = 1'($urandom_range(1));
            start_tensor(16'(w), 16'(h), 16'(c), 16'($urandom_range(5)), 16'($urandom));
            feed(n, 0, 1);
            finish_tensor(n, 16'(w), 16'(h), 16'(c));
            bp = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
